rs_dispatcher: RTL and testbench

- Issue stage between the decoder and the execution units.
- Takes one decoded instruction per cycle, resolves source operands from the register-file rename table, the RoB and both CDBs, and allocates a RoB entry.
- Sends the instruction to the reservation station (ALU/branch opcodes) or the LSB (opcodes 11..18) over the DPRS_*/DPLSB_* interfaces.
- One-entry holding register absorbs downstream back-pressure.

---
 rtl/rs_dispatcher.sv | 190 +++++++++++++++++++
 tb/tb_rs_dispatcher.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_dispatcher.sv
// rs_dispatcher: issue stage between the decoder and the RS / LSB.
// Resolves source operands at capture time, allocates a RoB entry and
// parks the instruction in a one-entry hold register. The held copy keeps
// watching both CDBs until the target unit accepts it.
module rs_dispatcher #(
  parameter int                       ADDR_WIDTH   = 32,
  parameter int                       EX_REG_WIDTH = 6,
  parameter logic [EX_REG_WIDTH-1:0]  NON_REG      = 6'b100000,
  parameter int                       RoB_WIDTH    = 8,
  parameter int                       EX_RoB_WIDTH = 9,
  parameter logic [EX_RoB_WIDTH-1:0]  NON_DEP      = 9'b100000000
) (
  input  logic                     Sys_clk,
  input  logic                     Sys_rst_n,
  input  logic                     Sys_rdy,
  input  logic                     DCDP_en,
  input  logic [ADDR_WIDTH-1:0]    DCDP_pc,
  input  logic [31:0]              DCDP_imm,
  input  logic [6:0]               DCDP_opcode,
  input  logic [EX_REG_WIDTH-1:0]  DCDP_rs1,
  input  logic [EX_REG_WIDTH-1:0]  DCDP_rs2,
  input  logic [EX_REG_WIDTH-1:0]  DCDP_rd,
  output logic                     DPDC_stall,
  output logic [EX_REG_WIDTH-1:0]  DPRF_rs1,
  output logic [EX_REG_WIDTH-1:0]  DPRF_rs2,
  input  logic [EX_RoB_WIDTH-1:0]  RFDP_Qj,
  input  logic [EX_RoB_WIDTH-1:0]  RFDP_Qk,
  input  logic [31:0]              RFDP_Vj,
  input  logic [31:0]              RFDP_Vk,
  input  logic                     RoBDP_j_ready,
  input  logic                     RoBDP_k_ready,
  input  logic [31:0]              RoBDP_j_value,
  input  logic [31:0]              RoBDP_k_value,
  input  logic                     RoBDP_full,
  input  logic [RoB_WIDTH-1:0]     RoBDP_tail,
  input  logic                     RoBDP_pre_judge,
  output logic                     DPRoB_en,
  output logic [6:0]               DPRoB_opcode,
  output logic [EX_REG_WIDTH-1:0]  DPRoB_rd,
  output logic [ADDR_WIDTH-1:0]    DPRoB_pc,
  output logic                     DPRF_en,
  input  logic                     RSCDB_en,
  input  logic [RoB_WIDTH-1:0]     RSCDB_RoB_index,
  input  logic [31:0]              RSCDB_value,
  input  logic                     CDBRS_LSB_en,
  input  logic [RoB_WIDTH-1:0]     CDBRS_LSB_RoB_index,
  input  logic [31:0]              CDBRS_LSB_value,
  input  logic                     RSDP_full,
  input  logic                     LSBDP_full,
  output logic                     DPRS_en,
  output logic                     DPLSB_en,
  output logic [ADDR_WIDTH-1:0]    DPRS_pc,
  output logic [EX_RoB_WIDTH-1:0]  DPRS_Qj,
  output logic [EX_RoB_WIDTH-1:0]  DPRS_Qk,
  output logic [31:0]              DPRS_Vj,
  output logic [31:0]              DPRS_Vk,
  output logic [31:0]              DPRS_imm,
  output logic [6:0]               DPRS_opcode,
  output logic [RoB_WIDTH-1:0]     DPRS_RoB_index
);

  localparam int QV_W = EX_RoB_WIDTH + 32;

  // Clear a pending tag that either CDB is broadcasting; the RS CDB wins a tie.
  function automatic logic [QV_W-1:0] f_snoop(
    input logic [EX_RoB_WIDTH-1:0] q,
    input logic [31:0]             v,
    input logic                    rs_en,
    input logic [RoB_WIDTH-1:0]    rs_idx,
    input logic [31:0]             rs_val,
    input logic                    lsb_en,
    input logic [RoB_WIDTH-1:0]    lsb_idx,
    input logic [31:0]             lsb_val
  );
    logic [QV_W-1:0] res;
    res = {q, v};
    if (q != NON_DEP && rs_en && rs_idx == q[RoB_WIDTH-1:0]) begin
      res = {NON_DEP, rs_val};
    end else if (q != NON_DEP && lsb_en && lsb_idx == q[RoB_WIDTH-1:0]) begin
      res = {NON_DEP, lsb_val};
    end else begin
      res = {q, v};
    end
    return res;
  endfunction

  // Capture-time operand lookup: no source, committed RF value, ready RoB
  // entry, then whatever the CDBs are delivering this very cycle.
  function automatic logic [QV_W-1:0] f_resolve(
    input logic [EX_REG_WIDTH-1:0] rs,
    input logic [EX_RoB_WIDTH-1:0] rf_q,
    input logic [31:0]             rf_v,
    input logic                    rob_rdy,
    input logic [31:0]             rob_val,
    input logic [QV_W-1:0]         cdb_res
  );
    logic [QV_W-1:0] res;
    if (rs == NON_REG || rs == {EX_REG_WIDTH{1'b0}}) begin
      res = {NON_DEP, 32'd0};
    end else if (rf_q == NON_DEP) begin
      res = {NON_DEP, rf_v};
    end else if (rob_rdy) begin
      res = {NON_DEP, rob_val};
    end else begin
      res = cdb_res;
    end
    return res;
  endfunction

  logic                    r_hold_valid;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [EX_RoB_WIDTH-1:0] r_qj, r_qk;
  logic [31:0]             r_vj, r_vk, r_imm;
  logic [6:0]              r_opcode;
  logic [RoB_WIDTH-1:0]    r_rob_index;

  logic                    w_is_mem, w_issue, w_capture;
  logic [QV_W-1:0]         w_res_j, w_res_k, w_hold_j, w_hold_k;

  // Issue/capture handshake and operand resolution for the incoming instruction.
  always_comb begin
    w_is_mem  = (r_opcode >= 7'd11) && (r_opcode <= 7'd18);
    w_issue   = r_hold_valid && Sys_rdy && RoBDP_pre_judge &&
                (w_is_mem ? !LSBDP_full : !RSDP_full);
    w_capture = Sys_rst_n && DCDP_en && !RoBDP_full && RoBDP_pre_judge && Sys_rdy &&
                (!r_hold_valid || w_issue);
    w_res_j   = f_resolve(DCDP_rs1, RFDP_Qj, RFDP_Vj, RoBDP_j_ready, RoBDP_j_value,
                  f_snoop(RFDP_Qj, 32'd0, RSCDB_en, RSCDB_RoB_index, RSCDB_value,
                          CDBRS_LSB_en, CDBRS_LSB_RoB_index, CDBRS_LSB_value));
    w_res_k   = f_resolve(DCDP_rs2, RFDP_Qk, RFDP_Vk, RoBDP_k_ready, RoBDP_k_value,
                  f_snoop(RFDP_Qk, 32'd0, RSCDB_en, RSCDB_RoB_index, RSCDB_value,
                          CDBRS_LSB_en, CDBRS_LSB_RoB_index, CDBRS_LSB_value));
    w_hold_j  = f_snoop(r_qj, r_vj, RSCDB_en, RSCDB_RoB_index, RSCDB_value,
                        CDBRS_LSB_en, CDBRS_LSB_RoB_index, CDBRS_LSB_value);
    w_hold_k  = f_snoop(r_qk, r_vk, RSCDB_en, RSCDB_RoB_index, RSCDB_value,
                        CDBRS_LSB_en, CDBRS_LSB_RoB_index, CDBRS_LSB_value);
  end

  // Hold register: flush, load on capture, drain on issue, otherwise snoop CDBs.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      r_hold_valid <= 1'b0;
      r_pc         <= '0;
      r_qj         <= '0;
      r_qk         <= '0;
      r_vj         <= 32'd0;
      r_vk         <= 32'd0;
      r_imm        <= 32'd0;
      r_opcode     <= 7'd0;
      r_rob_index  <= '0;
    end else if (Sys_rdy) begin
      if (!RoBDP_pre_judge) begin
        r_hold_valid <= 1'b0;
      end else if (w_capture) begin
        r_hold_valid <= 1'b1;
        r_pc         <= DCDP_pc;
        r_imm        <= DCDP_imm;
        r_opcode     <= DCDP_opcode;
        r_rob_index  <= RoBDP_tail;
        {r_qj, r_vj} <= w_res_j;
        {r_qk, r_vk} <= w_res_k;
      end else if (w_issue) begin
        r_hold_valid <= 1'b0;
      end else if (r_hold_valid) begin
        {r_qj, r_vj} <= w_hold_j;
        {r_qk, r_vk} <= w_hold_k;
      end
    end
  end

  assign DPRF_rs1       = DCDP_rs1;
  assign DPRF_rs2       = DCDP_rs2;
  assign DPRoB_en       = w_capture;
  assign DPRoB_opcode   = DCDP_opcode;
  assign DPRoB_rd       = DCDP_rd;
  assign DPRoB_pc       = DCDP_pc;
  assign DPRF_en        = w_capture && (DCDP_rd != NON_REG) && (DCDP_rd != {EX_REG_WIDTH{1'b0}});
  assign DPDC_stall     = RoBDP_full || (r_hold_valid && !w_issue) || !RoBDP_pre_judge;
  assign DPRS_en        = w_issue && !w_is_mem;
  assign DPLSB_en       = w_issue && w_is_mem;
  assign DPRS_pc        = r_pc;
  assign DPRS_Qj        = r_qj;
  assign DPRS_Qk        = r_qk;
  assign DPRS_Vj        = r_vj;
  assign DPRS_Vk        = r_vk;
  assign DPRS_imm       = r_imm;
  assign DPRS_opcode    = r_opcode;
  assign DPRS_RoB_index = r_rob_index;

endmodule

// File: tb/tb_rs_dispatcher.sv
// Directed bench for rs_dispatcher: reset, resolution priorities, hold
// snooping, back-to-back flow, flush and global-enable behaviour.
module tb_rs_dispatcher;
  localparam logic [5:0] NON_REG = 6'b100000;
  localparam logic [8:0] NON_DEP = 9'b100000000;

  logic        Sys_clk, Sys_rst_n, Sys_rdy;
  logic        DCDP_en;
  logic [31:0] DCDP_pc, DCDP_imm;
  logic [6:0]  DCDP_opcode;
  logic [5:0]  DCDP_rs1, DCDP_rs2, DCDP_rd;
  logic        DPDC_stall;
  logic [5:0]  DPRF_rs1, DPRF_rs2;
  logic [8:0]  RFDP_Qj, RFDP_Qk;
  logic [31:0] RFDP_Vj, RFDP_Vk;
  logic        RoBDP_j_ready, RoBDP_k_ready;
  logic [31:0] RoBDP_j_value, RoBDP_k_value;
  logic        RoBDP_full;
  logic [7:0]  RoBDP_tail;
  logic        RoBDP_pre_judge;
  logic        DPRoB_en;
  logic [6:0]  DPRoB_opcode;
  logic [5:0]  DPRoB_rd;
  logic [31:0] DPRoB_pc;
  logic        DPRF_en;
  logic        RSCDB_en;
  logic [7:0]  RSCDB_RoB_index;
  logic [31:0] RSCDB_value;
  logic        CDBRS_LSB_en;
  logic [7:0]  CDBRS_LSB_RoB_index;
  logic [31:0] CDBRS_LSB_value;
  logic        RSDP_full, LSBDP_full;
  logic        DPRS_en, DPLSB_en;
  logic [31:0] DPRS_pc;
  logic [8:0]  DPRS_Qj, DPRS_Qk;
  logic [31:0] DPRS_Vj, DPRS_Vk, DPRS_imm;
  logic [6:0]  DPRS_opcode;
  logic [7:0]  DPRS_RoB_index;

  int n_assert = 0;
  int n_fail   = 0;

  rs_dispatcher dut (
    .Sys_clk(Sys_clk), .Sys_rst_n(Sys_rst_n), .Sys_rdy(Sys_rdy),
    .DCDP_en(DCDP_en), .DCDP_pc(DCDP_pc), .DCDP_imm(DCDP_imm),
    .DCDP_opcode(DCDP_opcode), .DCDP_rs1(DCDP_rs1), .DCDP_rs2(DCDP_rs2),
    .DCDP_rd(DCDP_rd), .DPDC_stall(DPDC_stall),
    .DPRF_rs1(DPRF_rs1), .DPRF_rs2(DPRF_rs2),
    .RFDP_Qj(RFDP_Qj), .RFDP_Qk(RFDP_Qk), .RFDP_Vj(RFDP_Vj), .RFDP_Vk(RFDP_Vk),
    .RoBDP_j_ready(RoBDP_j_ready), .RoBDP_k_ready(RoBDP_k_ready),
    .RoBDP_j_value(RoBDP_j_value), .RoBDP_k_value(RoBDP_k_value),
    .RoBDP_full(RoBDP_full), .RoBDP_tail(RoBDP_tail),
    .RoBDP_pre_judge(RoBDP_pre_judge),
    .DPRoB_en(DPRoB_en), .DPRoB_opcode(DPRoB_opcode), .DPRoB_rd(DPRoB_rd),
    .DPRoB_pc(DPRoB_pc), .DPRF_en(DPRF_en),
    .RSCDB_en(RSCDB_en), .RSCDB_RoB_index(RSCDB_RoB_index), .RSCDB_value(RSCDB_value),
    .CDBRS_LSB_en(CDBRS_LSB_en), .CDBRS_LSB_RoB_index(CDBRS_LSB_RoB_index),
    .CDBRS_LSB_value(CDBRS_LSB_value),
    .RSDP_full(RSDP_full), .LSBDP_full(LSBDP_full),
    .DPRS_en(DPRS_en), .DPLSB_en(DPLSB_en), .DPRS_pc(DPRS_pc),
    .DPRS_Qj(DPRS_Qj), .DPRS_Qk(DPRS_Qk), .DPRS_Vj(DPRS_Vj), .DPRS_Vk(DPRS_Vk),
    .DPRS_imm(DPRS_imm), .DPRS_opcode(DPRS_opcode), .DPRS_RoB_index(DPRS_RoB_index)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    Sys_clk = 1'b0;
    forever #5 Sys_clk = ~Sys_clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic idle();
    Sys_rdy = 1'b1; DCDP_en = 1'b0; DCDP_pc = 32'd0; DCDP_imm = 32'd0;
    DCDP_opcode = 7'd0; DCDP_rs1 = NON_REG; DCDP_rs2 = NON_REG; DCDP_rd = NON_REG;
    RFDP_Qj = NON_DEP; RFDP_Qk = NON_DEP; RFDP_Vj = 32'd0; RFDP_Vk = 32'd0;
    RoBDP_j_ready = 1'b0; RoBDP_k_ready = 1'b0; RoBDP_j_value = 32'd0; RoBDP_k_value = 32'd0;
    RoBDP_full = 1'b0; RoBDP_tail = 8'd0; RoBDP_pre_judge = 1'b1;
    RSCDB_en = 1'b0; RSCDB_RoB_index = 8'd0; RSCDB_value = 32'd0;
    CDBRS_LSB_en = 1'b0; CDBRS_LSB_RoB_index = 8'd0; CDBRS_LSB_value = 32'd0;
    RSDP_full = 1'b0; LSBDP_full = 1'b0;
  endtask

  initial begin
    Sys_rst_n = 1'b0;
    idle();
    DCDP_en = 1'b1; DCDP_opcode = 7'd28;
    #1;
    chk("rst_dprs_en", DPRS_en, 1'b0);
    chk("rst_dplsb_en", DPLSB_en, 1'b0);
    chk("rst_dprob_en", DPRoB_en, 1'b0);
    chk("rst_payload_pc", DPRS_pc, 32'd0);
    tick(); tick();
    Sys_rst_n = 1'b1;
    idle();

    // Park an add behind a full RS, then pull reset while it could issue.
    DCDP_en = 1'b1; DCDP_opcode = 7'd28; DCDP_rs1 = 6'd1; DCDP_rd = 6'd4;
    RFDP_Vj = 32'h11; RoBDP_tail = 8'd2; RSDP_full = 1'b1;
    tick();
    DCDP_en = 1'b0;
    #1;
    chk("mid_hold_stall", DPDC_stall, 1'b1);
    chk("mid_hold_no_issue", DPRS_en, 1'b0);
    chk("mid_hold_index", DPRS_RoB_index, 8'd2);
    RSDP_full = 1'b0;
    #1;
    chk("mid_hold_issue_ready", DPRS_en, 1'b1);
    DCDP_en = 1'b1;
    Sys_rst_n = 1'b0;
    #1;
    chk("async_rst_dprs_en", DPRS_en, 1'b0);
    chk("async_rst_dplsb_en", DPLSB_en, 1'b0);
    chk("async_rst_dprob_en", DPRoB_en, 1'b0);
    chk("async_rst_index", DPRS_RoB_index, 8'd0);
    chk("async_rst_vj", DPRS_Vj, 32'd0);
    tick();
    Sys_rst_n = 1'b1;
    idle();

    // add x1(committed 5) + x2(RoB tag 3 ready, 7), tail 4.
    DCDP_en = 1'b1; DCDP_opcode = 7'd28; DCDP_pc = 32'h100;
    DCDP_rs1 = 6'd1; DCDP_rs2 = 6'd2; DCDP_rd = 6'd3;
    RFDP_Vj = 32'd5; RFDP_Qk = 9'd3; RFDP_Vk = 32'd99;
    RoBDP_k_ready = 1'b1; RoBDP_k_value = 32'd7; RoBDP_tail = 8'd4;
    #1;
    chk("add_dprob_en", DPRoB_en, 1'b1);
    chk("add_dprf_en", DPRF_en, 1'b1);
    chk("add_dprf_rs1", DPRF_rs1, 6'd1);
    chk("add_dprf_rs2", DPRF_rs2, 6'd2);
    chk("add_dprob_rd", DPRoB_rd, 6'd3);
    chk("add_dprob_pc", DPRoB_pc, 32'h100);
    chk("add_stall", DPDC_stall, 1'b0);
    chk("add_not_yet", DPRS_en, 1'b0);
    tick();
    idle();
    #1;
    chk("add_dprs_en", DPRS_en, 1'b1);
    chk("add_dplsb_en", DPLSB_en, 1'b0);
    chk("add_vj", DPRS_Vj, 32'd5);
    chk("add_vk", DPRS_Vk, 32'd7);
    chk("add_qj", DPRS_Qj, NON_DEP);
    chk("add_qk", DPRS_Qk, NON_DEP);
    chk("add_index", DPRS_RoB_index, 8'd4);
    chk("add_opcode", DPRS_opcode, 7'd28);
    chk("add_pc", DPRS_pc, 32'h100);
    tick();
    chk("add_drained", DPRS_en, 1'b0);

    // addi waiting on tag 6 behind a full RS; RS CDB delivers in cycle 2.
    DCDP_en = 1'b1; DCDP_opcode = 7'd19; DCDP_rs1 = 6'd5; DCDP_rd = 6'd7;
    DCDP_imm = 32'h20; RFDP_Qj = 9'd6; RoBDP_tail = 8'd10; RSDP_full = 1'b1;
    #1;
    chk("addi_dprob_en", DPRoB_en, 1'b1);
    tick();
    DCDP_en = 1'b0;
    #1;
    chk("addi_c1_stall", DPDC_stall, 1'b1);
    chk("addi_c1_qj", DPRS_Qj, 9'd6);
    tick();
    RSCDB_en = 1'b1; RSCDB_RoB_index = 8'd6; RSCDB_value = 32'h10;
    #1;
    chk("addi_c2_stall", DPDC_stall, 1'b1);
    tick();
    RSCDB_en = 1'b0;
    #1;
    chk("addi_c3_stall", DPDC_stall, 1'b1);
    chk("addi_c3_qj", DPRS_Qj, NON_DEP);
    tick();
    RSDP_full = 1'b0;
    #1;
    chk("addi_issue_en", DPRS_en, 1'b1);
    chk("addi_issue_qj", DPRS_Qj, NON_DEP);
    chk("addi_issue_vj", DPRS_Vj, 32'h10);
    chk("addi_issue_qk", DPRS_Qk, NON_DEP);
    chk("addi_issue_vk", DPRS_Vk, 32'd0);
    chk("addi_issue_imm", DPRS_imm, 32'h20);
    chk("addi_issue_index", DPRS_RoB_index, 8'd10);
    chk("addi_issue_stall", DPDC_stall, 1'b0);
    tick();
    idle();

    // Back-to-back lw then add; second add source resolved from RS CDB at capture.
    DCDP_en = 1'b1; DCDP_opcode = 7'd13; DCDP_rs1 = 6'd1; DCDP_rd = 6'd8;
    RFDP_Vj = 32'h40; RoBDP_tail = 8'd11;
    #1;
    chk("b2b_lw_stall", DPDC_stall, 1'b0);
    chk("b2b_lw_dprob", DPRoB_en, 1'b1);
    tick();
    DCDP_opcode = 7'd28; DCDP_rs1 = 6'd0; DCDP_rs2 = 6'd2; DCDP_rd = 6'd9;
    RFDP_Qj = 9'd5; RFDP_Vj = 32'h55; RFDP_Qk = 9'd12;
    RSCDB_en = 1'b1; RSCDB_RoB_index = 8'd12; RSCDB_value = 32'h77;
    RoBDP_tail = 8'd12;
    #1;
    chk("b2b_lsb_en", DPLSB_en, 1'b1);
    chk("b2b_lsb_rs_en", DPRS_en, 1'b0);
    chk("b2b_lw_vj", DPRS_Vj, 32'h40);
    chk("b2b_lw_index", DPRS_RoB_index, 8'd11);
    chk("b2b_add_stall", DPDC_stall, 1'b0);
    chk("b2b_add_dprob", DPRoB_en, 1'b1);
    tick();
    idle();
    #1;
    chk("b2b_rs_en", DPRS_en, 1'b1);
    chk("b2b_rs_lsb_en", DPLSB_en, 1'b0);
    chk("b2b_zero_reg_qj", DPRS_Qj, NON_DEP);
    chk("b2b_zero_reg_vj", DPRS_Vj, 32'd0);
    chk("b2b_cdb_qk", DPRS_Qk, NON_DEP);
    chk("b2b_cdb_vk", DPRS_Vk, 32'h77);
    chk("b2b_add_index", DPRS_RoB_index, 8'd12);
    chk("b2b_rs_stall", DPDC_stall, 1'b0);
    tick();

    // sw (opcode 18, memory boundary) waiting on tag 9; both CDBs fire together.
    DCDP_en = 1'b1; DCDP_opcode = 7'd18; DCDP_rs1 = 6'd3; DCDP_rd = NON_REG;
    RFDP_Qj = 9'd9; RoBDP_tail = 8'd13; LSBDP_full = 1'b1;
    #1;
    chk("sw_dprf_en", DPRF_en, 1'b0);
    chk("sw_dprob_en", DPRoB_en, 1'b1);
    tick();
    DCDP_en = 1'b0;
    RSCDB_en = 1'b1; RSCDB_RoB_index = 8'd9; RSCDB_value = 32'd1;
    CDBRS_LSB_en = 1'b1; CDBRS_LSB_RoB_index = 8'd9; CDBRS_LSB_value = 32'd2;
    #1;
    chk("sw_held_lsb_en", DPLSB_en, 1'b0);
    chk("sw_held_stall", DPDC_stall, 1'b1);
    chk("sw_held_qj", DPRS_Qj, 9'd9);
    tick();
    RSCDB_en = 1'b0; CDBRS_LSB_en = 1'b0; LSBDP_full = 1'b0;
    #1;
    chk("sw_issue_lsb_en", DPLSB_en, 1'b1);
    chk("sw_issue_rs_en", DPRS_en, 1'b0);
    chk("sw_issue_qj", DPRS_Qj, NON_DEP);
    chk("sw_issue_vj_rs_wins", DPRS_Vj, 32'd1);
    tick();
    idle();

    // bgeu (opcode 10) goes to the RS; mispredict flush kills issue and capture.
    DCDP_en = 1'b1; DCDP_opcode = 7'd10; RoBDP_tail = 8'd20; RSDP_full = 1'b1; LSBDP_full = 1'b1;
    tick();
    DCDP_opcode = 7'd28; DCDP_rd = 6'd5; RoBDP_tail = 8'd21; RSDP_full = 1'b0;
    #1;
    chk("bgeu_to_rs", DPRS_en, 1'b1);
    chk("bgeu_not_lsb", DPLSB_en, 1'b0);
    RoBDP_pre_judge = 1'b0;
    #1;
    chk("flush_dprs_en", DPRS_en, 1'b0);
    chk("flush_dprob_en", DPRoB_en, 1'b0);
    chk("flush_dprf_en", DPRF_en, 1'b0);
    chk("flush_stall", DPDC_stall, 1'b1);
    tick();
    idle();
    #1;
    chk("flush_hold_cleared", DPRS_en, 1'b0);
    chk("flush_stall_clear", DPDC_stall, 1'b0);

    // Global enable low: no capture, and a held instruction waits.
    Sys_rdy = 1'b0; DCDP_en = 1'b1; DCDP_opcode = 7'd28; RoBDP_tail = 8'd21;
    #1;
    chk("rdy_low_dprob", DPRoB_en, 1'b0);
    tick();
    Sys_rdy = 1'b1; DCDP_en = 1'b0;
    #1;
    chk("rdy_low_no_capture", DPRS_en, 1'b0);
    DCDP_en = 1'b1; DCDP_rs1 = 6'd4; RFDP_Qj = 9'd15; RoBDP_tail = 8'd22;
    CDBRS_LSB_en = 1'b1; CDBRS_LSB_RoB_index = 8'd15; CDBRS_LSB_value = 32'hAB;
    tick();
    idle();
    Sys_rdy = 1'b0;
    #1;
    chk("rdy_low_hold", DPRS_en, 1'b0);
    tick();
    Sys_rdy = 1'b1;
    #1;
    chk("rdy_high_issue", DPRS_en, 1'b1);
    chk("rdy_high_index", DPRS_RoB_index, 8'd22);
    chk("lsb_cdb_capture_vj", DPRS_Vj, 32'hAB);
    chk("lsb_cdb_capture_qj", DPRS_Qj, NON_DEP);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
